// File: rtl/id_stage.sv
// Instruction-decode stage: decodes a MIPS-subset instruction, selects operands and registers the ID/EX fields.
// Build option ID_FWD_EN enables operand forwarding; without it, any pending write to a read register stalls.
module id_stage #(
  parameter int DATA_W = 32,
  parameter int FWD_N  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pc_i,
  input  logic [31:0]             inst_i,
  input  logic                    inst_valid_i,
  input  logic [DATA_W-1:0]       reg1_data_i,
  input  logic [DATA_W-1:0]       reg2_data_i,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  output logic                    reg1_read_o,
  output logic                    reg2_read_o,
  input  logic [FWD_N-1:0]        fwd_wreg_i,
  input  logic [5*FWD_N-1:0]      fwd_wd_i,
  input  logic [DATA_W*FWD_N-1:0] fwd_wdata_i,
  input  logic                    ex_is_load_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic                    stallreq_o,
  output logic                    ex_valid_o,
  output logic [7:0]              ex_aluop_o,
  output logic [DATA_W-1:0]       ex_reg1_o,
  output logic [DATA_W-1:0]       ex_reg2_o,
  output logic                    ex_wreg_o,
  output logic [4:0]              ex_wd_o,
  output logic [31:0]             ex_pc_o
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_MOVZ = 6'h0A;
  localparam logic [5:0] FN_MOVN = 6'h0B;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [7:0] AOP_OR  = 8'h25;
  localparam logic [7:0] AOP_NOP = 8'h7C;

  logic [5:0]        op_s, fn_s;
  logic [4:0]        rs_s, rt_s, rd_s, sa_s;
  logic [15:0]       imm16_s;
  logic [7:0]        aluop_s;
  logic              wreg_s, re1_s, re2_s;
  logic [4:0]        wd_s;
  logic [DATA_W-1:0] imm_s, op1_s, op2_s;
  logic              hazard_s, stallreq_s;

  logic              valid_d, valid_q, wreg_d, wreg_q;
  logic [7:0]        aluop_d, aluop_q;
  logic [DATA_W-1:0] reg1_d, reg1_q, reg2_d, reg2_q;
  logic [4:0]        wd_d, wd_q;
  logic [31:0]       pc_d, pc_q;

  assign op_s    = inst_i[31:26];
  assign rs_s    = inst_i[25:21];
  assign rt_s    = inst_i[20:16];
  assign rd_s    = inst_i[15:11];
  assign sa_s    = inst_i[10:6];
  assign fn_s    = inst_i[5:0];
  assign imm16_s = inst_i[15:0];

  always_comb begin
    aluop_s = AOP_NOP;
    wreg_s  = 1'b0;
    wd_s    = 5'd0;
    re1_s   = 1'b0;
    re2_s   = 1'b0;
    imm_s   = {DATA_W{1'b0}};
    case (op_s)
      OP_SPECIAL: begin
        case (fn_s)
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLLV, FN_SRLV, FN_SRAV, FN_MOVZ, FN_MOVN: begin
            aluop_s = {2'b00, fn_s};
            wreg_s  = 1'b1;
            wd_s    = rd_s;
            re1_s   = 1'b1;
            re2_s   = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            aluop_s = (fn_s == FN_SLL) ? AOP_NOP : {2'b00, fn_s};
            wreg_s  = 1'b1;
            wd_s    = rd_s;
            re2_s   = 1'b1;
            imm_s   = DATA_W'(sa_s);
          end
          FN_MFHI, FN_MFLO: begin
            aluop_s = {2'b00, fn_s};
            wreg_s  = 1'b1;
            wd_s    = rd_s;
          end
          FN_MTHI, FN_MTLO: begin
            aluop_s = {2'b00, fn_s};
            re1_s   = 1'b1;
          end
          default: aluop_s = AOP_NOP;
        endcase
      end
      // andi/ori/xori map onto and/or/xor (0x24..0x26) via the low opcode bits.
      OP_ANDI, OP_ORI, OP_XORI: begin
        aluop_s = {6'b001001, op_s[1:0]};
        wreg_s  = 1'b1;
        wd_s    = rt_s;
        re1_s   = 1'b1;
        imm_s   = DATA_W'(imm16_s);
      end
      OP_LUI: begin
        aluop_s = AOP_OR;
        wreg_s  = 1'b1;
        wd_s    = rt_s;
        imm_s   = DATA_W'({imm16_s, 16'h0000});
      end
      default: aluop_s = AOP_NOP;
    endcase
  end

`ifdef ID_FWD_EN
  logic              fwd1_hit_s, fwd2_hit_s;
  logic [DATA_W-1:0] fwd1_data_s, fwd2_data_s;

  // Scan oldest to youngest so the lowest-index match is the one left standing.
  always_comb begin
    logic m1, m2;
    m1 = 1'b0;
    m2 = 1'b0;
    fwd1_hit_s  = 1'b0;
    fwd2_hit_s  = 1'b0;
    fwd1_data_s = {DATA_W{1'b0}};
    fwd2_data_s = {DATA_W{1'b0}};
    for (int i = FWD_N - 1; i >= 0; i--) begin
      m1 = fwd_wreg_i[i] && (fwd_wd_i[5*i +: 5] == rs_s);
      m2 = fwd_wreg_i[i] && (fwd_wd_i[5*i +: 5] == rt_s);
      fwd1_data_s = m1 ? fwd_wdata_i[DATA_W*i +: DATA_W] : fwd1_data_s;
      fwd2_data_s = m2 ? fwd_wdata_i[DATA_W*i +: DATA_W] : fwd2_data_s;
      fwd1_hit_s  = fwd1_hit_s | m1;
      fwd2_hit_s  = fwd2_hit_s | m2;
    end
  end

  assign hazard_s = ex_is_load_i && fwd_wreg_i[0] && (fwd_wd_i[4:0] != 5'd0) &&
                    ((re1_s && (fwd_wd_i[4:0] == rs_s)) || (re2_s && (fwd_wd_i[4:0] == rt_s)));
`else
  logic unused_fwd_s;

  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < FWD_N; i++) begin
      hazard_s = hazard_s | (fwd_wreg_i[i] &
                 ((re1_s & (rs_s != 5'd0) & (fwd_wd_i[5*i +: 5] == rs_s)) |
                  (re2_s & (rt_s != 5'd0) & (fwd_wd_i[5*i +: 5] == rt_s))));
    end
  end

  assign unused_fwd_s = ex_is_load_i ^ (^fwd_wdata_i);
`endif

  always_comb begin
    if (!re1_s) begin
      op1_s = imm_s;
    end else if (rs_s == 5'd0) begin
      op1_s = {DATA_W{1'b0}};
`ifdef ID_FWD_EN
    end else if (fwd1_hit_s) begin
      op1_s = fwd1_data_s;
`endif
    end else begin
      op1_s = reg1_data_i;
    end
  end

  always_comb begin
    if (!re2_s) begin
      op2_s = imm_s;
    end else if (rt_s == 5'd0) begin
      op2_s = {DATA_W{1'b0}};
`ifdef ID_FWD_EN
    end else if (fwd2_hit_s) begin
      op2_s = fwd2_data_s;
`endif
    end else begin
      op2_s = reg2_data_i;
    end
  end

  assign stallreq_s  = rst && inst_valid_i && hazard_s;
  assign stallreq_o  = stallreq_s;
  assign reg1_addr_o = rs_s;
  assign reg2_addr_o = rt_s;
  assign reg1_read_o = rst && re1_s;
  assign reg2_read_o = rst && re2_s;

  // Flush beats stall, stall beats the load-use bubble; bubbles and flushes clear every field.
  always_comb begin
    valid_d = valid_q;
    aluop_d = aluop_q;
    reg1_d  = reg1_q;
    reg2_d  = reg2_q;
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    pc_d    = pc_q;
    if (flush_i || (!stall_i && stallreq_s)) begin
      valid_d = 1'b0;
      aluop_d = 8'h00;
      reg1_d  = {DATA_W{1'b0}};
      reg2_d  = {DATA_W{1'b0}};
      wreg_d  = 1'b0;
      wd_d    = 5'd0;
      pc_d    = 32'h0000_0000;
    end else if (!stall_i) begin
      valid_d = inst_valid_i;
      aluop_d = aluop_s;
      reg1_d  = op1_s;
      reg2_d  = op2_s;
      wreg_d  = wreg_s && inst_valid_i;
      wd_d    = wd_s;
      pc_d    = pc_i;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      aluop_q <= 8'h00;
      reg1_q  <= {DATA_W{1'b0}};
      reg2_q  <= {DATA_W{1'b0}};
      wreg_q  <= 1'b0;
      wd_q    <= 5'd0;
      pc_q    <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      aluop_q <= aluop_d;
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
      pc_q    <= pc_d;
    end
  end

  assign ex_valid_o = valid_q;
  assign ex_aluop_o = aluop_q;
  assign ex_reg1_o  = reg1_q;
  assign ex_reg2_o  = reg2_q;
  assign ex_wreg_o  = wreg_q;
  assign ex_wd_o    = wd_q;
  assign ex_pc_o    = pc_q;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter DATA_W, default 32, register/immediate data width (>=32).
REQ-002 Parameter FWD_N, default 2, number of forwarding sources; index 0 = youngest (EX), FWD_N-1 = oldest.
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 pc_i  input  32  PC of instruction in ID.
REQ-006 inst_i  input  32  instruction word.
REQ-007 inst_valid_i  input  1  inst_i holds a real instruction.
REQ-008 reg1_data_i / reg2_data_i  input  DATA_W  regfile read data.
REQ-009 reg1_addr_o / reg2_addr_o  output  5  regfile read addresses (inst[25:21] / inst[20:16]).
REQ-010 reg1_read_o / reg2_read_o  output  1  combinational read enables.
REQ-011 fwd_wreg_i  input  FWD_N  per-source write enable.
REQ-012 fwd_wd_i  input  5*FWD_N  per-source destination register.
REQ-013 fwd_wdata_i  input  DATA_W*FWD_N  per-source result.
REQ-014 ex_is_load_i  input  1  source 0 is a load; its data not yet valid.
REQ-015 stall_i  input  1  downstream stall; hold output register.
REQ-016 flush_i  input  1  kill instruction entering output register.
REQ-017 stallreq_o  output  1  combinational; upstream holds PC/IF-ID.
REQ-018 ex_valid_o, ex_aluop_o[7:0], ex_reg1_o[DATA_W], ex_reg2_o[DATA_W], ex_wreg_o, ex_wd_o[4:0], ex_pc_o[31:0]  outputs  registered ID/EX stage.

Function
REQ-019 Decode: R-type funct and/or/xor/nor/srl/sra/sllv/srlv/srav/movn/movz/mfhi/mflo/mthi/mtlo -> aluop {2'b00,funct}; sll(funct 0) and sync -> 8'h7C; andi/ori/xori -> aluop of and/or/xor; lui -> or; unknown -> aluop 8'h7C, wreg 0, no reads.
REQ-020 movz SHALL encode 8'h0A, distinct from movn 8'h0B.
REQ-021 Immediates: andi/ori/xori zero-extend inst[15:0]; lui = inst[15:0]<<16; shift-by-shamt places inst[10:6] in operand 1; all zero-extended to DATA_W.
REQ-022 wd: rd for R-type, rt for I-type; mthi/mtlo/sync/unknown wreg 0.
REQ-023 Operand select per port: not read -> immediate; read addr 0 -> 0; else lowest-index source i with fwd_wreg_i[i]=1 and fwd_wd_i[i]==addr -> fwd_wdata_i[i]; else regfile data.
REQ-024 Load-use: stallreq_o=1 when inst_valid_i, ex_is_load_i, fwd_wreg_i[0], fwd_wd_i[0]!=0 and equals an enabled read address.
REQ-025 Output register update each edge, priority: flush_i -> ex_valid_o=0; else stall_i -> hold all; else stallreq_o -> bubble (ex_valid_o=0, ex_wreg_o=0); else load decoded fields, ex_valid_o=inst_valid_i.
REQ-026 Bubble/flush SHALL force ex_wreg_o=0; other fields don't-care but deterministic.
REQ-027 Latency: decode to ex_* one cycle; forwarding zero-cycle.
REQ-028 stall_i with stallreq_o: hold wins; stallreq_o stays asserted.

Reset
REQ-029 rst low: ex_valid_o=0, ex_aluop_o=0, ex_reg1_o=0, ex_reg2_o=0, ex_wreg_o=0, ex_wd_o=0, ex_pc_o=0, immediately.
REQ-030 While rst low, stallreq_o=0 and read enables=0; mid-operation reset discards in-flight instruction.

Configuration
REQ-031 Macro ID_FWD_EN defined: forwarding per REQ-023/024.
REQ-032 ID_FWD_EN undefined: no forwarding muxes; operands from regfile only; stallreq_o=1 on any enabled nonzero read address matching any fwd_wd_i[i] with fwd_wreg_i[i]=1.

Verification
REQ-033 ori r2,r1,0x00FF, r1=0x1200, no fwd -> next cycle aluop 8'h25, reg1 0x1200, reg2 0x000000FF, wd 2, wreg 1, valid 1.
REQ-034 or r3,r1,r2; src0 wd=1 data 0xA, src1 wd=1 data 0xB -> reg1 0xA (youngest wins); same with wd=0 -> regfile/zero used.
REQ-035 and r4,r5,r6; ex_is_load_i=1, src0 wd=5 -> stallreq_o=1, next ex_valid_o=0, ex_wreg_o=0; load cleared -> instruction issues.
REQ-036 stall_i=1 two cycles with new inst_i -> ex_* unchanged; flush_i with stall_i -> ex_valid_o=0.
REQ-037 movz vs movn -> 8'h0A vs 8'h0B; lui r7,0x1234 -> reg1 0x12340000, wd 7.
REQ-038 rst low mid-stream -> all ex_* zero asynchronously; without ID_FWD_EN, case REQ-034 -> stallreq_o=1.
